// File: rtl/bitsad_stream_pkg.sv
// Shared definitions for stochastic-stream decoders.
// Contents:
//   state_e     - fill-state of a windowed decoder (FILLING, STEADY)
//   count_width - bits needed to hold any value 0..n, i.e. ceil(log2(n+1))
package bitsad_stream_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    STEADY  = 1'b1
  } state_e;

  function automatic int count_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < (n + 1)) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/window_shift_line.sv
// Enabled, clearable bit shift line holding the most recent WINDOW bits.
// Newest bit enters at index 0; the bit at index WINDOW-1 is the one that
// leaves the window on the next accepted bit.
// Ports:
//   CLK    - rising-edge clock
//   RST    - synchronous active-high reset (clears the line)
//   clr    - synchronous flush (clears the line)
//   en     - shift strobe; x is shifted in when high
//   x      - incoming bit
//   oldest - bit at the far end of the line (registered)
module window_shift_line #(
  parameter int WINDOW = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic oldest
);

  logic [WINDOW-1:0] line;

  if (WINDOW == 1) begin : g_one
    always_ff @(posedge CLK) begin
      if (RST || clr) begin
        line <= '0;
      end else if (en) begin
        line <= x;
      end
    end
  end else begin : g_multi
    always_ff @(posedge CLK) begin
      if (RST || clr) begin
        line <= '0;
      end else if (en) begin
        line <= {line[WINDOW-2:0], x};
      end
    end
  end

  assign oldest = line[WINDOW-1];

endmodule

// File: rtl/sliding_window_decoder.sv
// Converts a unipolar stochastic bitstream into a binary count of the ones
// seen among the most recent WINDOW accepted bits.
// Ports:
//   CLK    - rising-edge clock
//   RST    - synchronous active-high reset
//   x      - stochastic input bit
//   en     - bit-accept strobe; x is consumed on an edge with en=1
//   clr    - synchronous flush of window and fill state
//   count  - ones among the last min(accepted, WINDOW) bits (registered)
//   full   - high once WINDOW bits have been accepted since reset/clr
//   update - one-cycle pulse: count was recomputed on the previous edge
module sliding_window_decoder
  import bitsad_stream_pkg::*;
#(
  parameter  int WINDOW  = 64,
  localparam int COUNT_W = count_width(WINDOW)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               x,
  input  logic               en,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               update
);

  localparam logic [COUNT_W-1:0] WIN = COUNT_W'(WINDOW);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] fill_q, fill_d;
  logic [COUNT_W-1:0] count_d;
  logic               full_d, update_d;
  logic               oldest, drop;
  logic [COUNT_W:0]   sum;

  window_shift_line #(.WINDOW(WINDOW)) u_line (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (clr),
    .en     (en),
    .x      (x),
    .oldest (oldest)
  );

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    count_d  = count;
    full_d   = full;
    update_d = en;
    drop     = 1'b0;
    sum      = '0;
    if (clr) begin
      state_d  = FILLING;
      fill_d   = '0;
      count_d  = '0;
      full_d   = 1'b0;
      update_d = 1'b0;
    end else if (en) begin
      // While filling, the far end of the line still holds the cleared
      // zeros, so nothing real leaves the window yet.
      drop    = (state_q == STEADY) ? oldest : 1'b0;
      sum     = {1'b0, count} + (COUNT_W+1)'(x) - (COUNT_W+1)'(drop);
      count_d = sum[COUNT_W-1:0];
      if (state_q == FILLING) begin
        fill_d = fill_q + 1'b1;
        if (fill_d == WIN) begin
          state_d = STEADY;
          full_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILLING;
      fill_q  <= '0;
      count   <= '0;
      full    <= 1'b0;
      update  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      count   <= count_d;
      full    <= full_d;
      update  <= update_d;
    end
  end

endmodule

// File: tb/tb_sliding_window_decoder.sv
// Directed bench for sliding_window_decoder at WINDOW = 4, 8 and 1.
// All three instances share the same stimulus; each check looks at the
// instance relevant to the scenario.
module tb_sliding_window_decoder;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic       x   = 1'b0;
  logic [2:0] c4;
  logic [3:0] c8;
  logic [0:0] c1;
  logic       f4, f8, f1, u4, u8, u1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sliding_window_decoder #(.WINDOW(4)) d4 (
    .CLK(clk), .RST(RST), .x(x), .en(en), .clr(clr),
    .count(c4), .full(f4), .update(u4)
  );
  sliding_window_decoder #(.WINDOW(8)) d8 (
    .CLK(clk), .RST(RST), .x(x), .en(en), .clr(clr),
    .count(c8), .full(f8), .update(u8)
  );
  sliding_window_decoder #(.WINDOW(1)) d1 (
    .CLK(clk), .RST(RST), .x(x), .en(en), .clr(clr),
    .count(c1), .full(f1), .update(u1)
  );

  typedef struct {
    logic rst, c, e, xv;
    int   cnt;
    logic fl, up;
  } vec_t;

  vec_t tab[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge take them, then sample 1 ns later.
  task automatic step(input logic r, input logic c, input logic e, input logic xv);
    RST = r; clr = c; en = e; x = xv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    int sum;
    logic [3:0] bits3;
    logic [7:0] bits8;
    logic [3:0] bits1;

    // Reset, all-ones fill/saturate, hold, clr, then mixed pattern (WINDOW=4)
    tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tab[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1};
    tab[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
    tab[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b1};
    tab[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b1};
    tab[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b1};
    tab[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b1};
    tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0};
    tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tab[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1};
    tab[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    tab[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
    tab[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1};
    tab[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1};
    tab[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1};

    for (int i = 0; i < 16; i++) begin
      step(tab[i].rst, tab[i].c, tab[i].e, tab[i].xv);
      chk($sformatf("tab%0d_count", i), int'(c4), tab[i].cnt);
      chk($sformatf("tab%0d_full", i), int'(f4), int'(tab[i].fl));
      chk($sformatf("tab%0d_update", i), int'(u4), int'(tab[i].up));
    end

    // Hold with a full window, then resume; expectations from a bit queue
    step(1'b0, 1'b1, 1'b0, 1'b0);
    q.delete();
    bits3 = 4'b1101;  // applied LSB first: 1,0,1,1
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, bits3[i]);
      q.push_back(int'(bits3[i]));
    end
    chk("hold_pre_count", int'(c4), 3);
    chk("hold_pre_full", int'(f4), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, logic'(i % 2));
      chk($sformatf("hold%0d_count", i), int'(c4), 3);
      chk($sformatf("hold%0d_update", i), int'(u4), 0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      q.push_back(0);
      if (q.size() > 4) void'(q.pop_front());
      sum = 0;
      foreach (q[k]) sum += q[k];
      chk($sformatf("resume%0d_count", i), int'(c4), sum);
      chk($sformatf("resume%0d_update", i), int'(u4), 1);
    end

    // clr together with en on a full WINDOW=8 window
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bits8 = 8'b1011_1011;  // six ones
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, bits8[i]);
    chk("w8_pre_count", int'(c8), 6);
    chk("w8_pre_full", int'(f8), 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("w8_clr_count", int'(c8), 0);
    chk("w8_clr_full", int'(f8), 0);
    chk("w8_clr_update", int'(u8), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("w8_a_count", int'(c8), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("w8_b_count", int'(c8), 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("w8_c_count", int'(c8), 2);
    chk("w8_c_full", int'(f8), 0);
    chk("w8_c_update", int'(u8), 1);

    // RST, clr and en together; then clr alone still flushes
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rstclr_count", int'(c4), 0);
    chk("rstclr_full", int'(f4), 0);
    chk("rstclr_update", int'(u4), 0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clronly_count", int'(c4), 0);
    chk("clronly_update", int'(u4), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("after_clr_count", int'(c4), 1);
    chk("after_clr_full", int'(f4), 0);

    // WINDOW=1 tracks the last bit; full from the first bit
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("w1_clr_full", int'(f1), 0);
    bits1 = 4'b1001;  // applied LSB first: 1,0,0,1
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, bits1[i]);
      chk($sformatf("w1_%0d_count", i), int'(c1), int'(bits1[i]));
      chk($sformatf("w1_%0d_full", i), int'(f1), 1);
      chk($sformatf("w1_%0d_update", i), int'(u1), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
